// File: rtl/spdif_frame_sequencer.sv
// spdif_frame_sequencer: frame-rate consumer of the stereo sample FIFO.
// Once per I2S frame it pops one stereo sample, presents registered audio
// words to the SPDIF transmitter, and generates validity, 192-frame block
// framing and the channel-status bit. It primes on a run of non-empty frames
// and rides through FIFO underruns.
//
// FIFO pop handshake: the FIFO is show-ahead, so fifo_empty=0 acts as "valid"
// for fifo_data_*. fifo_read_en is the "ready"/pop strobe; a word is consumed
// on a rising edge exactly when fifo_read_en=1 (which already implies
// fifo_empty=0), and that word is visible on data_* right after that edge.
module spdif_frame_sequencer #(
  parameter int unsigned PRIME_FRAMES  = 4,
  parameter logic        UNDERRUN_MUTE = 1'b1,
  parameter logic        COPY_PERMIT   = 1'b1,
  parameter logic [3:0]  WORDLEN_CODE  = 4'b1011
) (
  input  logic        pin_i2s_fclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data_left,
  input  logic [31:0] fifo_data_right,
  input  logic [3:0]  sample_rate_code,
  output logic        fifo_read_en,
  output logic [31:0] data_left,
  output logic [31:0] data_right,
  output logic        validity,
  output logic        block_start,
  output logic [7:0]  frame_index,
  output logic        cs_bit,
  output logic [7:0]  underrun_count,
  output logic        streaming,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } state_t;

  localparam logic [3:0] PRIME_TARGET = 4'(PRIME_FRAMES);

  state_t      r_state;
  logic [3:0]  r_prime_cnt;
  logic [31:0] r_data_left;
  logic [31:0] r_data_right;
  logic        r_validity;
  logic        r_block_start;
  logic [7:0]  r_frame_index;
  logic        r_cs_bit;
  logic [7:0]  r_underrun_count;
  logic [3:0]  r_shadow_rate;

  logic        w_streaming;
  logic        w_read_en;
  logic [7:0]  w_next_index;

  // Channel-status bit carried by the frame with index n.
  function automatic logic cs_for(input logic [7:0] n, input logic [3:0] rate);
    logic b;
    b = 1'b0;
    if (n == 8'd2)
      b = COPY_PERMIT;
    else if (n >= 8'd24 && n <= 8'd27)
      b = rate[n[1:0]];
    else if (n >= 8'd32 && n <= 8'd35)
      b = WORDLEN_CODE[n[1:0]];
    return b;
  endfunction

  assign w_streaming  = (r_state == RUN) || (r_state == UNDERRUN);
  // enable is folded in so that a falling enable suppresses the pop.
  assign w_read_en    = w_streaming && enable && !fifo_empty;
  assign w_next_index = (r_frame_index == 8'd191) ? 8'd0 : r_frame_index + 8'd1;

  // Frame sequencer FSM with all registered outputs.
  always_ff @(posedge pin_i2s_fclk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_prime_cnt      <= 4'd0;
      r_data_left      <= 32'd0;
      r_data_right     <= 32'd0;
      r_validity       <= 1'b0;
      r_block_start    <= 1'b0;
      r_frame_index    <= 8'd0;
      r_cs_bit         <= 1'b0;
      r_underrun_count <= 8'd0;
      r_shadow_rate    <= 4'd0;
    end else if (!enable) begin
      // Disable looks like reset except the underrun statistic survives.
      r_state       <= IDLE;
      r_prime_cnt   <= 4'd0;
      r_data_left   <= 32'd0;
      r_data_right  <= 32'd0;
      r_validity    <= 1'b0;
      r_block_start <= 1'b0;
      r_frame_index <= 8'd0;
      r_cs_bit      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state     <= PRIME;
          r_prime_cnt <= 4'd0;
        end
        PRIME: begin
          if (fifo_empty) begin
            r_prime_cnt <= 4'd0;
          end else if (r_prime_cnt + 4'd1 == PRIME_TARGET) begin
            // Stream starts at the top of a fresh block.
            r_state       <= RUN;
            r_prime_cnt   <= 4'd0;
            r_frame_index <= 8'd0;
            r_block_start <= 1'b1;
            r_cs_bit      <= cs_for(8'd0, sample_rate_code);
            r_shadow_rate <= sample_rate_code;
          end else begin
            r_prime_cnt <= r_prime_cnt + 4'd1;
          end
        end
        default: begin
          // RUN / UNDERRUN: the block counter runs every frame regardless of data.
          r_frame_index <= w_next_index;
          r_block_start <= (w_next_index == 8'd0);
          r_cs_bit      <= cs_for(w_next_index, r_shadow_rate);
          if (w_next_index == 8'd0)
            r_shadow_rate <= sample_rate_code;
          if (fifo_empty) begin
            r_state    <= UNDERRUN;
            r_validity <= 1'b0;
            if (UNDERRUN_MUTE) begin
              r_data_left  <= 32'd0;
              r_data_right <= 32'd0;
            end
            if (r_underrun_count != 8'hFF)
              r_underrun_count <= r_underrun_count + 8'd1;
          end else begin
            r_state      <= RUN;
            r_data_left  <= fifo_data_left;
            r_data_right <= fifo_data_right;
            r_validity   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign fifo_read_en   = w_read_en;
  assign data_left      = r_data_left;
  assign data_right     = r_data_right;
  assign validity       = r_validity;
  assign block_start    = r_block_start;
  assign frame_index    = r_frame_index;
  assign cs_bit         = r_cs_bit;
  assign underrun_count = r_underrun_count;
  assign streaming      = w_streaming;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// tb_spdif_frame_sequencer: directed bench with a data scoreboard and a
// small reference model for block framing and channel status. A second
// instance built with UNDERRUN_MUTE=0 shares the stimulus to cover the
// hold-last-sample underrun behaviour.
module tb_spdif_frame_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_data_left;
  logic [31:0] fifo_data_right;
  logic [3:0]  sample_rate_code;

  logic        fifo_read_en;
  logic [31:0] data_left;
  logic [31:0] data_right;
  logic        validity;
  logic        block_start;
  logic [7:0]  frame_index;
  logic        cs_bit;
  logic [7:0]  underrun_count;
  logic        streaming;
  logic [1:0]  dbg_state;

  logic        h_fifo_read_en;
  logic [31:0] h_data_left;
  logic [31:0] h_data_right;
  logic        h_validity;
  logic        h_block_start;
  logic [7:0]  h_frame_index;
  logic        h_cs_bit;
  logic [7:0]  h_underrun_count;
  logic        h_streaming;
  logic [1:0]  h_dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spdif_frame_sequencer dut (
    .pin_i2s_fclk    (clk),
    .rst             (rst),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_data_left  (fifo_data_left),
    .fifo_data_right (fifo_data_right),
    .sample_rate_code(sample_rate_code),
    .fifo_read_en    (fifo_read_en),
    .data_left       (data_left),
    .data_right      (data_right),
    .validity        (validity),
    .block_start     (block_start),
    .frame_index     (frame_index),
    .cs_bit          (cs_bit),
    .underrun_count  (underrun_count),
    .streaming       (streaming),
    .dbg_state       (dbg_state)
  );

  spdif_frame_sequencer #(.UNDERRUN_MUTE(1'b0)) dut_hold (
    .pin_i2s_fclk    (clk),
    .rst             (rst),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_data_left  (fifo_data_left),
    .fifo_data_right (fifo_data_right),
    .sample_rate_code(sample_rate_code),
    .fifo_read_en    (h_fifo_read_en),
    .data_left       (h_data_left),
    .data_right      (h_data_right),
    .validity        (h_validity),
    .block_start     (h_block_start),
    .frame_index     (h_frame_index),
    .cs_bit          (h_cs_bit),
    .underrun_count  (h_underrun_count),
    .streaming       (h_streaming),
    .dbg_state       (h_dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rq[$];
  int          m_idx;
  logic [3:0]  m_shadow;
  int          m_cnt;
  logic [31:0] m_last_l;
  logic [31:0] m_last_r;
  int          block_starts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_cs(input int n, input logic [3:0] sh);
    logic [3:0] wl;
    wl = 4'b1011;
    if (n == 2) return 1'b1;
    if (n >= 24 && n <= 27) return sh[2'(n - 24)];
    if (n >= 32 && n <= 35) return wl[2'(n - 32)];
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One streaming frame with enable=1: drive FIFO, check pop, advance model, check outputs.
  task automatic stream_frame(input logic empty, input logic [31:0] l);
    logic        exp_rd;
    logic [31:0] el;
    logic [31:0] er;
    int          nxt;
    fifo_empty      = empty;
    fifo_data_left  = l;
    fifo_data_right = ~l;
    #1;
    exp_rd = !empty;
    check("read_en", 32'(fifo_read_en), 32'(exp_rd));
    if (exp_rd) begin
      exp_q.push_back(l);
      exp_rq.push_back(~l);
    end
    nxt = (m_idx == 191) ? 0 : m_idx + 1;
    if (nxt == 0) m_shadow = sample_rate_code;
    m_idx = nxt;
    if (empty && m_cnt < 255) m_cnt++;
    tick();
    if (exp_rd) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        el = exp_q.pop_front();
        er = exp_rq.pop_front();
        check("data_left", data_left, el);
        check("data_right", data_right, er);
        check("hold_data_left", h_data_left, el);
        m_last_l = el;
        m_last_r = er;
      end
      check("validity_pop", 32'(validity), 32'd1);
      check("state_run", 32'(dbg_state), 32'd2);
    end else begin
      check("mute_left", data_left, 32'd0);
      check("mute_right", data_right, 32'd0);
      check("hold_left", h_data_left, m_last_l);
      check("hold_right", h_data_right, m_last_r);
      check("validity_underrun", 32'(validity), 32'd0);
      check("state_underrun", 32'(dbg_state), 32'd3);
    end
    check("frame_index", 32'(frame_index), 32'(m_idx));
    check("block_start", 32'(block_start), 32'(m_idx == 0));
    check("cs_bit", 32'(cs_bit), 32'(exp_cs(m_idx, m_shadow)));
    check("underrun_count", 32'(underrun_count), 32'(m_cnt));
    check("streaming", 32'(streaming), 32'd1);
    if (block_start) block_starts++;
  endtask

  task automatic check_all_zero(input string tag, input logic [31:0] exp_cnt);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_data_left"}, data_left, 32'd0);
    check({tag, "_data_right"}, data_right, 32'd0);
    check({tag, "_validity"}, 32'(validity), 32'd0);
    check({tag, "_block_start"}, 32'(block_start), 32'd0);
    check({tag, "_frame_index"}, 32'(frame_index), 32'd0);
    check({tag, "_cs_bit"}, 32'(cs_bit), 32'd0);
    check({tag, "_streaming"}, 32'(streaming), 32'd0);
    check({tag, "_underrun_count"}, 32'(underrun_count), exp_cnt);
  endtask

  task automatic model_start();
    m_idx    = 0;
    m_shadow = sample_rate_code;
    m_last_l = 32'd0;
    m_last_r = 32'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pat;
    checks           = 0;
    errors           = 0;
    block_starts     = 0;
    m_cnt            = 0;
    rst              = 1'b1;
    enable           = 1'b0;
    fifo_empty       = 1'b1;
    fifo_data_left   = 32'd0;
    fifo_data_right  = 32'd0;
    sample_rate_code = 4'b1100;

    // Reset state
    tick();
    tick();
    check_all_zero("reset", 32'd0);
    check("reset_read_en", 32'(fifo_read_en), 32'd0);

    // IDLE -> PRIME with an empty FIFO (prime count stays at zero)
    rst    = 1'b0;
    enable = 1'b1;
    #1;
    check("idle_read_en", 32'(fifo_read_en), 32'd0);
    tick();
    check("to_prime", 32'(dbg_state), 32'd1);

    // Four non-empty frames: RUN on the 4th edge, no pops while priming
    for (int i = 0; i < 4; i++) begin
      fifo_empty     = 1'b0;
      fifo_data_left = 32'h1111_0000 + 32'(i);
      #1;
      check("prime_read_en", 32'(fifo_read_en), 32'd0);
      tick();
      check("prime_streaming", 32'(streaming), 32'(i == 3));
    end
    check("entry_frame_index", 32'(frame_index), 32'd0);
    check("entry_block_start", 32'(block_start), 32'd1);
    check("entry_validity", 32'(validity), 32'd0);
    check("entry_data", data_left, 32'd0);
    check("entry_cs", 32'(cs_bit), 32'd0);
    model_start();
    block_starts = 1;

    // 440 streaming frames; rate code changes mid block 1
    for (int k = 0; k < 440; k++) begin
      if (k == 200) sample_rate_code = 4'b0001;
      stream_frame(1'b0, 32'hA5A5_0001 + 32'(k));
    end
    check("block_start_total", 32'(block_starts), 32'd3);

    // Underrun for three frames, then recovery
    for (int i = 0; i < 3; i++) stream_frame(1'b1, 32'h0);
    check("underrun_cnt3", 32'(underrun_count), 32'd3);
    check("hold_underrun_cnt3", 32'(h_underrun_count), 32'd3);
    stream_frame(1'b0, 32'hDEAD_BEEF);

    // Run to frame_index 100, then reset mid block
    while (m_idx != 100) stream_frame(1'b0, $urandom);
    check("pre_reset_index", 32'(frame_index), 32'd100);
    rst        = 1'b1;
    fifo_empty = 1'b0;
    tick();
    check_all_zero("midrst", 32'd0);
    m_cnt = 0;

    // Re-prime with an interruption: non-empty x3, empty x1, non-empty x4
    rst        = 1'b0;
    fifo_empty = 1'b1;
    tick();
    check("reprime_state", 32'(dbg_state), 32'd1);
    pat = 8'b0000_1000;
    for (int i = 0; i < 8; i++) begin
      fifo_empty = pat[i];
      #1;
      check("reprime_read_en", 32'(fifo_read_en), 32'd0);
      tick();
      check("reprime_streaming", 32'(streaming), 32'(i == 7));
    end
    check("reprime_index", 32'(frame_index), 32'd0);
    check("reprime_block_start", 32'(block_start), 32'd1);
    model_start();

    // One pop, one underrun, then enable falls while a pop is possible
    stream_frame(1'b0, $urandom);
    stream_frame(1'b1, 32'h0);
    enable     = 1'b0;
    fifo_empty = 1'b0;
    #1;
    check("disable_read_en", 32'(fifo_read_en), 32'd0);
    tick();
    check_all_zero("disable", 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_frame_sequencer.md
Name: spdif_frame_sequencer

Overview:
- Frame-rate read-side controller between the sample FIFO and the SPDIF transmitter; the consumer end of the FIFO that the I2S receiver fills.
- Once per I2S frame it pops one stereo sample from the FIFO and presents registered left/right audio words to the SPDIF transmitter.
- It also generates the validity flag, the 192-frame block framing (block_start and frame index) and the channel-status bit for the frame.
- It detects FIFO underrun and recovers from it.

Parameters:
- PRIME_FRAMES, 4: number of consecutive non-empty frames required before streaming starts (range 1..15).
- UNDERRUN_MUTE, 1: on underrun, 1 outputs zero samples, 0 repeats the last sample.
- COPY_PERMIT, 1: value of channel-status bit 2.
- WORDLEN_CODE, 4'b1011: value of channel-status bits 32..35 (bit 32+i = WORDLEN_CODE[i]).

Ports:
- pin_i2s_fclk  in  1  frame clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  streaming permitted (from system management unit).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_left  in  32  FIFO head word, left channel (show-ahead, valid while fifo_empty=0).
- fifo_data_right  in  32  FIFO head word, right channel.
- sample_rate_code  in  4  channel-status sample-rate field.
- fifo_read_en  out  1  pop request (combinational).
- data_left  out  32  registered left sample to the SPDIF transmitter.
- data_right  out  32  registered right sample.
- validity  out  1  registered; 1 = data_left/data_right carry real audio.
- block_start  out  1  registered; 1 during frame 0 of a 192-frame block.
- frame_index  out  8  registered; 0..191.
- cs_bit  out  1  registered channel-status bit for the current frame.
- underrun_count  out  8  saturating count of underrun frames.
- streaming  out  1  1 while state is RUN or UNDERRUN.

Behaviour:
- Reset, and also rst taking effect mid-operation, forces all of the following on the next edge:
  - state := IDLE.
  - data_left/data_right := 0; validity, block_start, cs_bit, streaming := 0.
  - frame_index := 0; underrun_count := 0; prime counter := 0.
- States and transitions:
  - IDLE: go to PRIME when enable=1.
  - PRIME: the prime counter increments on each edge with fifo_empty=0 and clears on each edge with fifo_empty=1. Go to RUN on the edge where the counter would reach PRIME_FRAMES. No pops occur in PRIME.
  - RUN: go to UNDERRUN on an edge with fifo_empty=1.
  - UNDERRUN: go back to RUN on an edge with fifo_empty=0.
  - From any state, enable=0 returns to IDLE on the next edge, with the same output values as reset except underrun_count, which is held.
- fifo_read_en = (state==RUN or state==UNDERRUN) and enable and not fifo_empty.
- Each edge with fifo_read_en=1:
  - data_left/data_right := FIFO head words.
  - validity := 1.
- Each edge in RUN/UNDERRUN with fifo_empty=1:
  - validity := 0.
  - Data := 0 if UNDERRUN_MUTE=1, else data is held.
  - underrun_count increments, saturating at 255.
- Latency: a FIFO head word appears on data_* one fclk edge after fifo_read_en is asserted.
- Frame counter:
  - While streaming, frame_index advances 0→1→…→191→0 on every edge, whether or not a pop occurs.
  - Entry to RUN from PRIME loads frame_index=0.
  - UNDERRUN does not reset the block counter.
- block_start = (frame_index==0), registered together with frame_index.
- Channel status:
  - sample_rate_code is latched into a shadow register on each edge where the next frame_index is 0; changes take effect only at block boundaries.
  - cs_bit for the frame with index n:
    - n=2: COPY_PERMIT.
    - n=24..27: shadow[n-24].
    - n=32..35: WORDLEN_CODE[n-32].
    - All other n: 0.
  - cs_bit is registered alongside frame_index.
- Simultaneous events:
  - enable falling while a pop is possible: enable wins, no pop.
  - rst has priority over everything.
- Outputs outside streaming: data_* = 0, validity = 0, block_start = 0, cs_bit = 0.

Test Plan:
- Reset, then enable=1 with the FIFO non-empty for 4 frames → streaming=1 on the 4th edge and fifo_read_en=1 on the next frame. Within that first stream frame: frame_index=0, block_start=1. No pops occur before that.
- Prime interrupted: non-empty ×3, empty ×1, non-empty ×4 → RUN is reached only after the final 4 consecutive non-empty frames.
- Stream 400 frames of left=32'hA5A5_0001+k → data_left equals the kth word one edge after its pop; block_start=1 at stream frames 0, 192 and 384; frame_index wraps 191→0.
- sample_rate_code=4'b1100, COPY_PERMIT=1 → cs_bit=1 at n=2, 26, 27, 32, 33, 35 and 0 elsewhere. Change the code to 4'b0001 mid-block → the new value appears at n=24 only in the next block.
- fifo_empty=1 for 3 frames during RUN, UNDERRUN_MUTE=1 → validity=0, data=0, underrun_count=3, frame_index keeps counting, and streaming resumes with validity=1 once the FIFO is non-empty. With UNDERRUN_MUTE=0 → data holds the last sample.
- rst asserted mid-block at frame_index=100 → next edge: all outputs 0, state IDLE; re-priming restarts frame_index at 0.
